// File: rtl/frame_commit_ctrl.sv
// frame_commit_ctrl
// -----------------
// Collects a dibit-serial receive frame into a circular byte buffer. A frame
// only becomes visible downstream once its checksum verdict arrives and is
// good. A failed, malformed, overlong or unresolved frame is rolled back by
// rewinding the write pointer to where the frame started.
//
// Build option: FRAME_COMMIT_FCS_STRIP_EN
//   defined   - the last 4 bytes of each committed frame (FCS) are rewound
//               and never reach the output.
//   undefined - the whole frame, FCS included, is output.
//
// Parameters
//   DEPTH      buffer size in bytes (power of two, >= 64)
//   CK_TIMEOUT cycles to wait in WAIT_CK for ck_done before dropping
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   axiiv, axiid      receive dibit valid / dibit (first dibit -> bits [1:0])
//   ck_done, ck_kill  checksum verdict strobe / verdict is bad
//   axiov, axiod      registered committed-byte output
//   axiready          downstream accepts axiod this cycle
//   frame_ok          one-cycle pulse: frame committed
//   frame_drop        one-cycle pulse: frame discarded
module frame_commit_ctrl #(
    parameter int DEPTH      = 2048,
    parameter int CK_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       axiiv,
    input  logic [1:0] axiid,
    input  logic       ck_done,
    input  logic       ck_kill,
    output logic       axiov,
    output logic [7:0] axiod,
    input  logic       axiready,
    output logic       frame_ok,
    output logic       frame_drop
);

    localparam int AW = $clog2(DEPTH) + 1;
    localparam int TW = $clog2(CK_TIMEOUT + 1);

`ifdef FRAME_COMMIT_FCS_STRIP_EN
    localparam logic [AW-1:0] FCS_LEN = AW'(4);
`else
    localparam logic [AW-1:0] FCS_LEN = AW'(0);
`endif

    typedef enum logic [1:0] {IDLE, RECV, WAIT_CK, SKIP} state_t;

    state_t          r_state;
    state_t          w_next_state;

    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW-1:0]   r_commit_ptr;
    logic [AW-1:0]   r_frame_start;
    logic [7:0]      r_mem [DEPTH];

    logic [5:0]      r_sr;      // first three dibits of the byte in progress
    logic [1:0]      r_dcnt;
    logic [2:0]      r_bcnt;    // bytes seen this frame, saturating at 5
    logic            r_ovf;     // frame hit a full buffer
    logic            r_part;    // frame ended mid-byte
    logic [TW-1:0]   r_tcnt;
    logic            r_armed;   // axiiv seen low since reset

    logic            r_ov;
    logic [7:0]      r_od;

    logic            w_start;
    logic            w_capture;
    logic            w_full;
    logic            w_we;
    logic            w_err;
    logic            w_commit;
    logic            w_drop;
    logic            w_fire;
    logic [AW-1:0]   w_rd_next;

    assign w_full    = (r_wr_ptr - r_rd_ptr) == AW'(DEPTH);
    assign w_capture = w_start || (r_state == RECV && axiiv);
    assign w_we      = w_capture && (r_dcnt == 2'd3) && !w_full && !r_ovf;
    assign w_err     = r_ovf || r_part || (r_bcnt < 3'd5);

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        w_start      = 1'b0;
        w_commit     = 1'b0;
        w_drop       = 1'b0;
        case (r_state)
            IDLE: begin
                // A frame already running when reset released is not ours.
                if (axiiv) begin
                    if (r_armed) begin
                        w_next_state = RECV;
                        w_start      = 1'b1;
                    end else begin
                        w_next_state = SKIP;
                    end
                end
            end
            RECV: begin
                if (!axiiv) w_next_state = WAIT_CK;
            end
            WAIT_CK: begin
                // A verdict arriving together with a new frame still counts;
                // a new frame without a verdict forces the drop.
                if (ck_done) begin
                    if (!ck_kill && !w_err) w_commit = 1'b1;
                    else                    w_drop   = 1'b1;
                end else if (axiiv || r_tcnt == TW'(CK_TIMEOUT - 1)) begin
                    w_drop = 1'b1;
                end
                if (w_commit || w_drop) w_next_state = axiiv ? SKIP : IDLE;
            end
            SKIP: begin
                if (!axiiv) w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    assign frame_ok   = w_commit;
    assign frame_drop = w_drop;

    // ------------------------------------------------------- write side
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr      <= '0;
            r_commit_ptr  <= '0;
            r_frame_start <= '0;
            r_sr          <= '0;
            r_dcnt        <= '0;
            r_bcnt        <= '0;
            r_ovf         <= 1'b0;
            r_part        <= 1'b0;
            r_tcnt        <= '0;
            r_armed       <= 1'b0;
        end else begin
            if (!axiiv) r_armed <= 1'b1;

            if (w_start) begin
                r_frame_start <= r_wr_ptr;
                r_bcnt        <= '0;
                r_ovf         <= 1'b0;
                r_part        <= 1'b0;
            end

            if (w_capture) begin
                r_sr   <= {axiid, r_sr[5:2]};
                r_dcnt <= r_dcnt + 2'd1;
                if (r_dcnt == 2'd3) begin
                    if (r_bcnt != 3'd5) r_bcnt <= r_bcnt + 3'd1;
                    // Once full, the rest of the frame is discarded so the
                    // buffer never wraps onto unread data.
                    if (w_full || r_ovf) r_ovf <= 1'b1;
                end
            end else begin
                r_dcnt <= '0;
            end

            if (r_state == RECV && !axiiv) r_part <= (r_dcnt != 2'd0);

            if (r_state == WAIT_CK) r_tcnt <= r_tcnt + TW'(1);
            else                    r_tcnt <= '0;

            if (w_we) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end else if (w_commit) begin
                r_commit_ptr <= r_wr_ptr - FCS_LEN;
                r_wr_ptr     <= r_wr_ptr - FCS_LEN;
            end else if (w_drop) begin
                r_wr_ptr <= r_frame_start;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_we) r_mem[r_wr_ptr[AW-2:0]] <= {axiid, r_sr};
    end

    // ------------------------------------------------------- read side
    // rd_ptr names the byte held in the output register. On a stall the
    // same slot is reloaded; it cannot be overwritten because the full test
    // is made against rd_ptr.
    assign w_fire    = r_ov && axiready;
    assign w_rd_next = r_rd_ptr + {{(AW-1){1'b0}}, w_fire};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_ov     <= 1'b0;
            r_od     <= '0;
        end else begin
            r_rd_ptr <= w_rd_next;
            if (w_rd_next != r_commit_ptr) begin
                r_ov <= 1'b1;
                r_od <= r_mem[w_rd_next[AW-2:0]];
            end else begin
                r_ov <= 1'b0;
            end
        end
    end

    assign axiov = r_ov;
    assign axiod = r_od;

endmodule

// File: tb/tb_frame_commit_ctrl.sv
// Scoreboard bench for frame_commit_ctrl (DEPTH=64, CK_TIMEOUT=16).
`timescale 1ns/1ps
module tb_frame_commit_ctrl;

    localparam int DEPTH      = 64;
    localparam int CK_TIMEOUT = 16;
`ifdef FRAME_COMMIT_FCS_STRIP_EN
    localparam int STRIP = 4;
`else
    localparam int STRIP = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       axiiv = 1'b0;
    logic [1:0] axiid = 2'd0;
    logic       ck_done = 1'b0;
    logic       ck_kill = 1'b0;
    logic       axiready = 1'b0;
    logic       axiov;
    logic [7:0] axiod;
    logic       frame_ok;
    logic       frame_drop;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];      // committed bytes in expected output order
    bit         pulse_q[$];    // 1 = frame_ok expected, 0 = frame_drop
    logic [7:0] fb [0:127];    // payload of the frame being sent
    int         n_pop = 0;
    int         ready_mode = 0;  // 0 fixed, 1 random, 2 toggle
    bit         ready_fix = 1'b0;
    int         model_wr = 0;    // bytes kept in buffer, mod 2*DEPTH

    frame_commit_ctrl #(.DEPTH(DEPTH), .CK_TIMEOUT(CK_TIMEOUT)) dut (
        .clk(clk), .rst(rst), .axiiv(axiiv), .axiid(axiid),
        .ck_done(ck_done), .ck_kill(ck_kill), .axiov(axiov), .axiod(axiod),
        .axiready(axiready), .frame_ok(frame_ok), .frame_drop(frame_drop)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       axiready = ready_fix;
            1:       axiready = ($urandom % 4) != 0;
            default: axiready = ~axiready;
        endcase
    end

    // ---------------------------------------------------------- monitor
    logic       prev_stall = 1'b0;
    logic [7:0] prev_d = 8'h00;
    logic [7:0] eb;
    bit         ep;

    always @(negedge clk) begin
        if (!rst) begin
            if (prev_stall) begin
                checks++;
                if (!axiov || axiod !== prev_d) begin
                    errors++;
                    $display("FAIL hold: axiov=%0b axiod=%02h, required axiov=1 axiod=%02h",
                             axiov, axiod, prev_d);
                end
            end
            if (axiov && axiready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL byte: unexpected byte %02h, required none", axiod);
                end else begin
                    eb = exp_q.pop_front();
                    if (axiod !== eb) begin
                        errors++;
                        $display("FAIL byte: got %02h required %02h", axiod, eb);
                    end
                end
                n_pop++;
            end
            if (frame_ok || frame_drop) begin
                checks++;
                if (frame_ok && frame_drop) begin
                    errors++;
                    $display("FAIL pulse: frame_ok and frame_drop together, required one");
                end else if (pulse_q.size() == 0) begin
                    errors++;
                    $display("FAIL pulse: unexpected ok=%0b drop=%0b, required none",
                             frame_ok, frame_drop);
                end else begin
                    ep = pulse_q.pop_front();
                    if (frame_ok !== ep) begin
                        errors++;
                        $display("FAIL pulse: got ok=%0b drop=%0b required ok=%0b",
                                 frame_ok, frame_drop, ep);
                    end
                end
            end
        end
        prev_stall = !rst && axiov && !axiready;
        prev_d     = axiod;
    end

    // ---------------------------------------------------------- helpers
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic drive_bytes(input int n, input int extra);
        for (int i = 0; i < n; i++)
            for (int k = 0; k < 4; k++) begin
                axiiv = 1'b1;
                axiid = fb[i][2*k +: 2];
                @(posedge clk); #1;
            end
        for (int k = 0; k < extra; k++) begin
            axiiv = 1'b1;
            axiid = 2'($urandom);
            @(posedge clk); #1;
        end
        axiiv = 1'b0;
    endtask

    task automatic wait_resolved(input string tag);
        int c;
        c = 0;
        while (pulse_q.size() != 0 && c < 60) begin
            @(posedge clk);
            c++;
        end
        if (pulse_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s: no frame pulse in 60 cycles, required %0d pending", tag, pulse_q.size());
            pulse_q.delete();
        end
        @(posedge clk); #1;
        chk({tag, " wr_ptr"}, int'(dut.r_wr_ptr), model_wr);
    endtask

    task automatic drain(input string tag);
        int c;
        c = 0;
        while (exp_q.size() != 0 && c < 2000) begin
            @(posedge clk);
            c++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s: %0d bytes never output, required 0", tag, exp_q.size());
            exp_q.delete();
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    // d = cycles after the fall that ck_done is presented; d < 1 means never
    task automatic run_frame(input int n, input int extra, input int d,
                             input bit kill, input string tag);
        bit good;
        int first;
        good = !kill && extra == 0 && n >= 5 && n <= DEPTH && d >= 1 && d <= CK_TIMEOUT;
        if (good) begin
            for (int i = 0; i < n - STRIP; i++) exp_q.push_back(fb[i]);
            model_wr = (model_wr + n - STRIP) % (2 * DEPTH);
        end
        pulse_q.push_back(good);
        drive_bytes(n, extra);
        if (d < 1) begin
            first = 0;
            for (int j = 1; j <= CK_TIMEOUT + 4 && first == 0; j++) begin
                @(posedge clk);
                @(negedge clk);
                if (frame_drop) first = j;
            end
            chk({tag, " timeout cycle"}, first, CK_TIMEOUT);
        end else begin
            repeat (d) @(posedge clk);
            #1;
            ck_done = 1'b1;
            ck_kill = kill;
            @(posedge clk); #1;
            ck_done = 1'b0;
            ck_kill = 1'b0;
        end
        wait_resolved(tag);
    endtask

    task automatic fill_rand(input int n);
        for (int i = 0; i < n; i++) fb[i] = 8'($urandom);
    endtask

    task automatic fill_seq(input int n);
        for (int i = 0; i < n; i++) fb[i] = 8'(i);
    endtask

    // ---------------------------------------------------------- stimulus
    initial begin
        int base;
        int n, extra, d;
        bit kill;

        // Reset with a frame already running on the line.
        ready_fix = 1'b1;
        axiiv     = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst axiov", int'(axiov), 0);
        chk("rst axiod", int'(axiod), 0);
        chk("rst pulses", int'(frame_ok) + int'(frame_drop), 0);
        chk("rst wr_ptr", int'(dut.r_wr_ptr), 0);
        rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            axiid = 2'($urandom);
            @(posedge clk); #1;
        end
        axiiv = 1'b0;
        repeat (CK_TIMEOUT + 6) @(posedge clk);
        #1;
        chk("inflight wr_ptr", int'(dut.r_wr_ptr), 0);

        // Good 64-byte frame.
        fill_seq(64);
        base = n_pop;
        run_frame(64, 0, 2, 1'b0, "good64");
        drain("good64");
        chk("good64 count", n_pop - base, 64 - STRIP);

        // Same frame, checksum bad.
        base = n_pop;
        run_frame(64, 0, 2, 1'b1, "kill64");
        drain("kill64");
        chk("kill64 count", n_pop - base, 0);

        // Partial byte, minimum length, timeout.
        fill_rand(10);
        run_frame(10, 1, 2, 1'b0, "partial");
        fill_rand(4);
        run_frame(4, 0, 3, 1'b0, "short4");
        fill_rand(5);
        run_frame(5, 0, CK_TIMEOUT, 1'b0, "min5");
        drain("min5");
        fill_rand(20);
        run_frame(20, 0, 0, 1'b0, "timeout");

        // New frame starts while verdict is pending: drop, ignore the frame.
        fill_rand(8);
        pulse_q.push_back(1'b0);
        drive_bytes(8, 0);
        @(posedge clk); #1;
        drive_bytes(2, 0);
        wait_resolved("skip");
        repeat (CK_TIMEOUT + 4) @(posedge clk);
        #1;
        chk("skip wr_ptr", int'(dut.r_wr_ptr), model_wr);

        // Overflow with a stalled output, then a good frame.
        ready_fix = 1'b0;
        fill_rand(70);
        run_frame(70, 0, 2, 1'b0, "ovf70");
        fill_rand(20);
        base = n_pop;
        run_frame(20, 0, 2, 1'b0, "after_ovf");
        repeat (4) @(posedge clk);
        #1;
        chk("stalled axiov", int'(axiov), 1);
        ready_fix = 1'b1;
        drain("after_ovf");
        chk("after_ovf count", n_pop - base, 20 - STRIP);

        // Randomised frames with random back-pressure.
        ready_mode = 1;
        for (int it = 0; it < 24; it++) begin
            n     = $urandom_range(1, 48);
            extra = ($urandom % 5 == 0) ? $urandom_range(1, 3) : 0;
            kill  = ($urandom % 4 == 0);
            d     = $urandom_range(1, CK_TIMEOUT);
            fill_rand(n);
            run_frame(n, extra, d, kill, "rand");
            drain("rand");
        end

        // Reset in the middle of output.
        ready_mode = 0;
        ready_fix  = 1'b0;
        fill_seq(60);
        run_frame(60, 0, 2, 1'b0, "rst60");
        base = n_pop;
        ready_mode = 2;
        for (int c = 0; c < 200 && n_pop < base + 5; c++) begin
            @(posedge clk); #1;
        end
        chk("rst60 bytes before reset", n_pop - base, 5);
        rst        = 1'b1;
        ready_mode = 0;
        #1;
        chk("midrst axiov", int'(axiov), 0);
        chk("midrst rd_ptr", int'(dut.r_rd_ptr), 0);
        chk("midrst commit_ptr", int'(dut.r_commit_ptr), 0);
        chk("midrst wr_ptr", int'(dut.r_wr_ptr), 0);
        exp_q.delete();
        pulse_q.delete();
        model_wr = 0;
        repeat (3) @(posedge clk);
        #1;
        rst       = 1'b0;
        ready_fix = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        fill_rand(12);
        base = n_pop;
        run_frame(12, 0, 2, 1'b0, "post_rst");
        drain("post_rst");
        chk("post_rst count", n_pop - base, 12 - STRIP);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        errors++;
        $display("FAIL watchdog: simulation did not complete");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1);
    end

endmodule

// File: doc/frame_commit_ctrl.md
FRAME_COMMIT_CTRL -- requirements
Module: frame_commit_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 2048: byte capacity of the frame buffer; power of two, at least 64.
REQ-002 SHALL have parameter CK_TIMEOUT, default 16: maximum number of cycles to wait for a checksum verdict after frame end.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port axiiv, input, 1 bit: receive dibit valid; high for the whole frame.
REQ-006 SHALL have port axiid, input, 2 bits: receive dibit.
REQ-007 SHALL have port ck_done, input, 1 bit: checksum verdict available.
REQ-008 SHALL have port ck_kill, input, 1 bit: checksum bad; qualified by ck_done.
REQ-009 SHALL have port axiov, output, 1 bit: committed byte valid.
REQ-010 SHALL have port axiod, output, 8 bits: committed byte.
REQ-011 SHALL have port axiready, input, 1 bit: downstream accepts a byte.
REQ-012 SHALL have port frame_ok, output, 1 bit: one-cycle pulse when a frame is committed.
REQ-013 SHALL have port frame_drop, output, 1 bit: one-cycle pulse when a frame is discarded.

Function
REQ-014 SHALL assemble dibits LSB-first: the first dibit of each group of 4 goes to bits [1:0] and the fourth to bits [7:6]; each completed byte is written at wr_ptr.
REQ-015 SHALL implement states IDLE, RECV, WAIT_CK and SKIP.
- IDLE -> RECV on axiiv=1; frame_start is latched from wr_ptr.
- RECV -> WAIT_CK on axiiv falling.
REQ-016 SHALL resolve WAIT_CK at the first cycle with ck_done=1.
- ck_kill=0 and no error: commit, pulse frame_ok.
- Otherwise: set wr_ptr to frame_start, pulse frame_drop.
- Both cases return to IDLE.
REQ-017 SHALL treat a frame as an error (drop at resolution regardless of ck_kill) in each of these cases:
- a partial byte (dibit count not a multiple of 4) at frame end;
- fewer than 5 bytes;
- a write attempted while the buffer is full, in which case further writes of that frame are suppressed.
REQ-018 SHALL, if ck_done has not arrived within CK_TIMEOUT cycles in WAIT_CK, drop the frame and pulse frame_drop.
REQ-019 SHALL, when axiiv rises while in WAIT_CK, resolve the pending verdict and enter SKIP, not RECV; SKIP ignores all dibits and returns to IDLE on axiiv=0 with no pulse.
REQ-020 SHALL use pointers of width log2(DEPTH)+1 that wrap modulo 2*DEPTH; full means wr_ptr-rd_ptr=DEPTH and empty means rd_ptr=commit_ptr.
REQ-021 SHALL present bytes from rd_ptr up to commit_ptr in a registered output stage.
- axiov is asserted no earlier than 1 cycle after commit.
- axiod is held stable while axiov=1 and axiready=0.
- rd_ptr advances on axiov&&axiready, sustaining one byte per cycle.
REQ-022 SHALL keep frames contiguous and in arrival order on the output; frame_ok and frame_drop SHALL never be asserted in the same cycle.

Reset
REQ-023 SHALL, on rst=1, asynchronously clear wr_ptr, rd_ptr, commit_ptr, frame_start, the dibit counter and the timeout counter, and enter state IDLE.
REQ-024 SHALL drive axiov=0, axiod=0, frame_ok=0 and frame_drop=0 during reset.
REQ-025 SHALL discard any uncommitted and unread data on reset mid-frame or mid-output, with no pulse.
REQ-026 SHALL, after rst falls, remain in IDLE until axiiv is first seen low; a frame already in progress goes to SKIP.

Configuration
REQ-027 SHALL implement macro FRAME_COMMIT_FCS_STRIP_EN.
- Defined: commit sets commit_ptr=wr_ptr-4, and wr_ptr is then also set to wr_ptr-4, so the 4 FCS bytes are never output.
- Undefined: commit_ptr=wr_ptr and FCS bytes are output.
- The minimum-length rule (REQ-017) applies in both cases.

Verification
REQ-028 SHALL cover: a 64-byte frame (bytes 0x00..0x3F, including FCS), ck_done=1 with ck_kill=0 two cycles after axiiv falls, axiready=1 -> frame_ok pulses; 60 bytes 0x00..0x3B out with STRIP, 64 without; no frame_drop.
REQ-029 SHALL cover: the same frame with ck_kill=1 -> frame_drop pulses, axiov stays 0, and wr_ptr returns to its pre-frame value.
REQ-030 SHALL cover: a 10-byte frame plus 1 extra dibit, checksum good -> frame_drop pulses and no output.
REQ-031 SHALL cover: DEPTH=64, axiready=0, and a 70-byte frame -> frame_drop pulses; then a good 20-byte frame -> frame_ok pulses and 16 or 20 bytes are output in order once axiready=1.
REQ-032 SHALL cover: ck_done never asserted -> frame_drop pulses exactly CK_TIMEOUT cycles after axiiv falls.
REQ-033 SHALL cover: rst asserted mid-output after 5 of 60 bytes, with axiready toggling 1/0 every cycle -> axiov=0 immediately, pointers=0, and the next frame is output from its first byte.
